// File: rtl/arbitro_escrita_banco.sv
// Round-robin arbiter sharing the register-bank write port between ULA (A) and memory/load (B).
// Optional macro ARBITRO_ADIANTAMENTO_EN adds forwarding of the pending write to the rs/rt read values.
module arbitro_escrita_banco #(
    parameter int unsigned LARGURA_DADO = 32,
    parameter int unsigned LARGURA_END  = 5
) (
    input  logic                    clock,
    input  logic                    reset_n,
    input  logic                    valid_a,
    input  logic [LARGURA_END-1:0]  rd_a,
    input  logic [LARGURA_DADO-1:0] dado_a,
    output logic                    ready_a,
    input  logic                    valid_b,
    input  logic [LARGURA_END-1:0]  rd_b,
    input  logic [LARGURA_DADO-1:0] dado_b,
    output logic                    ready_b,
    input  logic                    congela,
    output logic                    RegWrite,
    output logic [LARGURA_END-1:0]  rd,
    output logic [LARGURA_DADO-1:0] dado_escrita,
`ifdef ARBITRO_ADIANTAMENTO_EN
    input  logic [LARGURA_END-1:0]  rs,
    input  logic [LARGURA_END-1:0]  rt,
    input  logic [LARGURA_DADO-1:0] dado1_banco,
    input  logic [LARGURA_DADO-1:0] dado2_banco,
    output logic [LARGURA_DADO-1:0] dado1,
    output logic [LARGURA_DADO-1:0] dado2,
`endif
    output logic                    ocupado
);

    logic                    r_pend_valid;
    logic [LARGURA_END-1:0]  r_pend_rd;
    logic [LARGURA_DADO-1:0] r_pend_dado;
    logic                    r_ultimo_b;

    logic w_livre;
    logic w_grant_a;
    logic w_grant_b;

    // Stage accepts a new entry when empty or draining; never while reset is held.
    always_comb begin
        w_livre   = reset_n && (!r_pend_valid || !congela);
        w_grant_a = w_livre && valid_a && (!valid_b || r_ultimo_b);
        w_grant_b = w_livre && valid_b && (!valid_a || !r_ultimo_b);
    end

    assign ready_a      = w_grant_a;
    assign ready_b      = w_grant_b;
    assign ocupado      = r_pend_valid;
    // r0 is hardwired to zero, so its writes are swallowed here.
    assign RegWrite     = r_pend_valid && !congela && (r_pend_rd != '0);
    assign rd           = r_pend_rd;
    assign dado_escrita = r_pend_dado;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_pend_valid <= 1'b0;
            r_pend_rd    <= '0;
            r_pend_dado  <= '0;
            r_ultimo_b   <= 1'b1;
        end else if (w_grant_a) begin
            r_pend_valid <= 1'b1;
            r_pend_rd    <= rd_a;
            r_pend_dado  <= dado_a;
            r_ultimo_b   <= 1'b0;
        end else if (w_grant_b) begin
            r_pend_valid <= 1'b1;
            r_pend_rd    <= rd_b;
            r_pend_dado  <= dado_b;
            r_ultimo_b   <= 1'b1;
        end else if (r_pend_valid && !congela) begin
            r_pend_valid <= 1'b0;
        end
    end

`ifdef ARBITRO_ADIANTAMENTO_EN
    // Pending value bypasses the bank until it is actually written, frozen or not.
    assign dado1 = (r_pend_valid && (r_pend_rd == rs) && (rs != '0)) ? r_pend_dado : dado1_banco;
    assign dado2 = (r_pend_valid && (r_pend_rd == rt) && (rt != '0)) ? r_pend_dado : dado2_banco;
`endif

endmodule

// File: tb/tb_arbitro_escrita_banco.sv
// Self-checking bench for arbitro_escrita_banco: expected bank writes are queued at grant
// time and popped by a monitor whenever RegWrite is seen.
module tb_arbitro_escrita_banco;

    localparam int unsigned LD = 32;
    localparam int unsigned LE = 5;

    typedef struct {
        logic [LE-1:0] rd;
        logic [LD-1:0] dado;
    } escrita_t;

    logic          clock = 1'b0;
    logic          reset_n;
    logic          valid_a, valid_b, congela;
    logic [LE-1:0] rd_a, rd_b;
    logic [LD-1:0] dado_a, dado_b;
    logic          ready_a, ready_b, RegWrite, ocupado;
    logic [LE-1:0] rd;
    logic [LD-1:0] dado_escrita;
`ifdef ARBITRO_ADIANTAMENTO_EN
    logic [LE-1:0] rs, rt;
    logic [LD-1:0] dado1_banco, dado2_banco, dado1, dado2;
`endif

    escrita_t esperado[$];
    int erros = 0;
    int verif = 0;

    arbitro_escrita_banco #(.LARGURA_DADO(LD), .LARGURA_END(LE)) dut (
        .clock(clock), .reset_n(reset_n),
        .valid_a(valid_a), .rd_a(rd_a), .dado_a(dado_a), .ready_a(ready_a),
        .valid_b(valid_b), .rd_b(rd_b), .dado_b(dado_b), .ready_b(ready_b),
        .congela(congela), .RegWrite(RegWrite), .rd(rd), .dado_escrita(dado_escrita),
`ifdef ARBITRO_ADIANTAMENTO_EN
        .rs(rs), .rt(rt), .dado1_banco(dado1_banco), .dado2_banco(dado2_banco),
        .dado1(dado1), .dado2(dado2),
`endif
        .ocupado(ocupado)
    );

    always #5 clock = ~clock;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    // Every bank write must match the oldest queued expectation.
    always @(negedge clock) begin
        if (RegWrite === 1'b1) begin
            verif++;
            if (esperado.size() == 0) begin
                erros++;
                $display("FAIL write_unexpected: got rd=%0d dado=%0h, none expected", rd, dado_escrita);
            end else begin
                escrita_t e;
                e = esperado.pop_front();
                if (rd !== e.rd || dado_escrita !== e.dado) begin
                    erros++;
                    $display("FAIL write_data: got rd=%0d dado=%0h, want rd=%0d dado=%0h",
                             rd, dado_escrita, e.rd, e.dado);
                end
            end
        end
    end

    task automatic prox();
        @(posedge clock);
        #1;
    endtask

    task automatic zera_entradas();
        valid_a = 1'b0; rd_a = '0; dado_a = '0;
        valid_b = 1'b0; rd_b = '0; dado_b = '0;
        congela = 1'b0;
`ifdef ARBITRO_ADIANTAMENTO_EN
        rs = '0; rt = '0; dado1_banco = '0; dado2_banco = '0;
`endif
    endtask

    task automatic aplica_reset();
        zera_entradas();
        reset_n = 1'b0;
        @(posedge clock);
        @(posedge clock);
        #1;
        reset_n = 1'b1;
    endtask

    task automatic test_reset();
        zera_entradas();
        reset_n = 1'b0;
        valid_a = 1'b1; rd_a = 5'd7; valid_b = 1'b1; rd_b = 5'd9;
        @(negedge clock);
        verif++;
        if (ocupado !== 1'b0 || RegWrite !== 1'b0 || rd !== '0 || dado_escrita !== '0) begin
            erros++;
            $display("FAIL reset_outputs: ocupado=%b RegWrite=%b rd=%0d dado=%0h, want all 0",
                     ocupado, RegWrite, rd, dado_escrita);
        end
        verif++;
        if (ready_a !== 1'b0 || ready_b !== 1'b0) begin
            erros++;
            $display("FAIL reset_ready: ready_a=%b ready_b=%b, want 0 0", ready_a, ready_b);
        end
        @(posedge clock);
        #1;
        zera_entradas();
        reset_n = 1'b1;
        prox();
    endtask

    task automatic test_basico();
        valid_a = 1'b1; rd_a = 5'd4; dado_a = 32'd8;
        @(negedge clock);
        verif++;
        if (ready_a !== 1'b1 || ready_b !== 1'b0) begin
            erros++;
            $display("FAIL basic_ready: ready_a=%b ready_b=%b, want 1 0", ready_a, ready_b);
        end
        esperado.push_back('{rd: 5'd4, dado: 32'd8});
        prox();
        valid_a = 1'b0;
        @(negedge clock);
        verif++;
        if (RegWrite !== 1'b1 || ocupado !== 1'b1) begin
            erros++;
            $display("FAIL basic_write: RegWrite=%b ocupado=%b, want 1 1", RegWrite, ocupado);
        end
        prox();
        @(negedge clock);
        verif++;
        if (RegWrite !== 1'b0 || ocupado !== 1'b0) begin
            erros++;
            $display("FAIL basic_drain: RegWrite=%b ocupado=%b, want 0 0", RegWrite, ocupado);
        end
        prox();
    endtask

    task automatic test_round_robin();
        logic vez_a;
        aplica_reset();
        vez_a = 1'b1;
        valid_a = 1'b1; rd_a = 5'd1; dado_a = 32'h11;
        valid_b = 1'b1; rd_b = 5'd2; dado_b = 32'h22;
        for (int k = 0; k < 4; k++) begin
            @(negedge clock);
            verif++;
            if (ready_a !== vez_a || ready_b !== !vez_a) begin
                erros++;
                $display("FAIL rr_grant%0d: ready_a=%b ready_b=%b, want %b %b",
                         k, ready_a, ready_b, vez_a, !vez_a);
            end
            if (vez_a) esperado.push_back('{rd: 5'd1, dado: 32'h11});
            else       esperado.push_back('{rd: 5'd2, dado: 32'h22});
            vez_a = !vez_a;
            prox();
        end
        valid_a = 1'b0; valid_b = 1'b0;
        prox();
        prox();
    endtask

    task automatic test_congela();
        valid_a = 1'b1; rd_a = 5'd6; dado_a = 32'd15;
        @(negedge clock);
        verif++;
        if (ready_a !== 1'b1) begin
            erros++;
            $display("FAIL freeze_load: ready_a=%b, want 1", ready_a);
        end
        esperado.push_back('{rd: 5'd6, dado: 32'd15});
        prox();
        valid_a = 1'b0; congela = 1'b1;
        valid_b = 1'b1; rd_b = 5'd9; dado_b = 32'h33;
        for (int k = 0; k < 3; k++) begin
            @(negedge clock);
            verif++;
            if (RegWrite !== 1'b0 || ready_b !== 1'b0 || ocupado !== 1'b1 ||
                rd !== 5'd6 || dado_escrita !== 32'd15) begin
                erros++;
                $display("FAIL freeze_hold%0d: RegWrite=%b ready_b=%b ocupado=%b rd=%0d dado=%0h, want 0 0 1 6 f",
                         k, RegWrite, ready_b, ocupado, rd, dado_escrita);
            end
            prox();
        end
        congela = 1'b0;
        @(negedge clock);
        verif++;
        if (RegWrite !== 1'b1 || ready_b !== 1'b1) begin
            erros++;
            $display("FAIL freeze_release: RegWrite=%b ready_b=%b, want 1 1", RegWrite, ready_b);
        end
        esperado.push_back('{rd: 5'd9, dado: 32'h33});
        prox();
        valid_b = 1'b0;
        prox();
        prox();
    endtask

    task automatic test_r0();
        valid_a = 1'b1; rd_a = 5'd0; dado_a = 32'hFFFF;
        @(negedge clock);
        verif++;
        if (ready_a !== 1'b1) begin
            erros++;
            $display("FAIL r0_ready: ready_a=%b, want 1", ready_a);
        end
        prox();
        valid_a = 1'b0;
        @(negedge clock);
        verif++;
        if (ocupado !== 1'b1 || RegWrite !== 1'b0) begin
            erros++;
            $display("FAIL r0_pending: ocupado=%b RegWrite=%b, want 1 0", ocupado, RegWrite);
        end
        prox();
        @(negedge clock);
        verif++;
        if (ocupado !== 1'b0) begin
            erros++;
            $display("FAIL r0_drain: ocupado=%b, want 0", ocupado);
        end
        prox();
    endtask

    task automatic test_reset_meio();
        valid_a = 1'b1; rd_a = 5'd3; dado_a = 32'h55;
        @(negedge clock);
        verif++;
        if (ready_a !== 1'b1) begin
            erros++;
            $display("FAIL midreset_load: ready_a=%b, want 1", ready_a);
        end
        prox();
        valid_a = 1'b0;
        #1;
        reset_n = 1'b0;
        #1;
        verif++;
        if (RegWrite !== 1'b0 || ocupado !== 1'b0) begin
            erros++;
            $display("FAIL midreset_async: RegWrite=%b ocupado=%b, want 0 0", RegWrite, ocupado);
        end
        @(posedge clock);
        #1;
        reset_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clock);
            verif++;
            if (ocupado !== 1'b0 || RegWrite !== 1'b0) begin
                erros++;
                $display("FAIL midreset_after%0d: ocupado=%b RegWrite=%b, want 0 0", k, ocupado, RegWrite);
            end
            prox();
        end
    endtask

`ifdef ARBITRO_ADIANTAMENTO_EN
    task automatic test_adiantamento();
        rs = 5'd4; rt = 5'd5; dado1_banco = 32'd0; dado2_banco = 32'd7;
        valid_a = 1'b1; rd_a = 5'd4; dado_a = 32'd8;
        @(negedge clock);
        esperado.push_back('{rd: 5'd4, dado: 32'd8});
        prox();
        valid_a = 1'b0; congela = 1'b1;
        @(negedge clock);
        verif++;
        if (dado1 !== 32'd8 || dado2 !== 32'd7) begin
            erros++;
            $display("FAIL fwd_rs: dado1=%0h dado2=%0h, want 8 7", dado1, dado2);
        end
        prox();
        congela = 1'b0;
        prox();
        valid_a = 1'b1; rd_a = 5'd0; dado_a = 32'hAB;
        rs = 5'd0; dado1_banco = 32'h12;
        prox();
        valid_a = 1'b0;
        @(negedge clock);
        verif++;
        if (ocupado !== 1'b1 || dado1 !== 32'h12) begin
            erros++;
            $display("FAIL fwd_r0: ocupado=%b dado1=%0h, want 1 12", ocupado, dado1);
        end
        prox();
        prox();
    endtask
`endif

    initial begin
        zera_entradas();
        reset_n = 1'b0;
        test_reset();
        test_basico();
        test_round_robin();
        test_congela();
        test_r0();
        test_reset_meio();
`ifdef ARBITRO_ADIANTAMENTO_EN
        test_adiantamento();
`endif
        prox();
        verif++;
        if (esperado.size() != 0) begin
            erros++;
            $display("FAIL writes_missing: %0d expected writes never seen, want 0", esperado.size());
        end
        $display("Result: errors=%0d of %0d checks", erros, verif);
        $finish;
    end

endmodule
